// File: rtl/vga_window_address.sv
// rtl/vga_window_address.sv - VGA framebuffer read-address generator for a square image window
//
// Purpose: turns the sync block's x/y counters into data-memory read addresses
// for a square window at (H_ORIGIN, V_ORIGIN). The image dimension is fetched
// from DIM_ADDR at every frame start and the display mode is latched there.
// Modes: 0 original image, 1 interpolated quadrant, 2 2x pixel-replicated zoom
// (3 behaves as 0).
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   pix_tick      one-cycle pixel strobe, x/y valid while high
//   x, y          sync counters
//   mode          display mode request, sampled only at frame start
//   mem_rdata     memory read data (dimension during the fetch)
//   mem_addr      read address (dimension word or pixel)
//   addr_valid    mem_addr is a pixel request
//   pixel_en      addr_valid delayed MEM_LAT cycles, aligned with read data
//   dim_q         image dimension used this frame
//   frame_start   one-cycle pulse when the dimension fetch is launched
module vga_window_address #(
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned DIM_W       = 16,
    parameter int unsigned H_ORIGIN    = 145,
    parameter int unsigned V_ORIGIN    = 35,
    parameter int unsigned DIM_ADDR    = 2,
    parameter int unsigned BASE_ORIG   = 5,
    parameter int unsigned BASE_INTERP = 'h3D289,
    parameter int unsigned DIM_DEFAULT = 392,
    parameter int unsigned MAX_DIM     = 480,
    parameter int unsigned MEM_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_tick,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [1:0]         mode,
    input  logic [DIM_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               addr_valid,
    output logic               pixel_en,
    output logic [DIM_W-1:0]   dim_q,
    output logic               frame_start
);

    // Window arithmetic is done wide enough that origin + 2*dim never wraps.
    localparam int unsigned CW    = ((DIM_W > COORD_W) ? DIM_W : COORD_W) + 3;
    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [CW-1:0]     H_ORG    = CW'(H_ORIGIN);
    localparam logic [CW-1:0]     V_ORG    = CW'(V_ORIGIN);
    localparam logic [ADDR_W-1:0] A_DIM    = ADDR_W'(DIM_ADDR);
    localparam logic [ADDR_W-1:0] A_ORIG   = ADDR_W'(BASE_ORIG);
    localparam logic [ADDR_W-1:0] A_INTERP = ADDR_W'(BASE_INTERP);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);
    localparam logic [DIM_W-1:0]  D_DEF    = DIM_W'(DIM_DEFAULT);
    localparam logic [DIM_W-1:0]  D_MAX    = DIM_W'(MAX_DIM);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, FETCH, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0]  row_start_q, row_start_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               addr_valid_q, addr_valid_d;
    logic               frame_start_q, frame_start_d;
    logic [DIM_W-1:0]   dim_d;
    logic [MEM_LAT-1:0] pen_sr_q, pen_sr_d;

    logic [CW-1:0] dim_ext, quarter3, win_w, x_ext, y_ext, h_end, v_end;
    logic          frame_tick, in_win, last_col, col_odd, row_odd, dim_ok;

    always_comb begin
        dim_ext  = CW'(dim_q);
        quarter3 = (dim_ext >> 2) * CW'(3);
        case (mode_q)
            2'd1:    win_w = (quarter3 >= CW'(2)) ? quarter3 - CW'(2) : '0;
            2'd2:    win_w = dim_ext << 1;
            default: win_w = dim_ext;
        endcase
        x_ext  = CW'(x);
        y_ext  = CW'(y);
        h_end  = H_ORG + win_w;
        v_end  = V_ORG + win_w;
        in_win = (x_ext >= H_ORG) && (x_ext < h_end) && (y_ext >= V_ORG) && (y_ext < v_end);
        // Parity of the window-relative column/row, without forming the differences.
        col_odd    = x_ext[0] ^ H_ORG[0];
        row_odd    = y_ext[0] ^ V_ORG[0];
        last_col   = (x_ext == h_end - CW'(1));
        frame_tick = pix_tick && (x == '0) && (y == '0);
        dim_ok     = (mem_rdata != '0) && (mem_rdata <= D_MAX);
    end

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cnt_d         = cnt_q;
        ptr_d         = ptr_q;
        row_start_d   = row_start_q;
        mem_addr_d    = mem_addr_q;
        addr_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        dim_d         = dim_q;
        pen_sr_d      = (pen_sr_q << 1) | MEM_LAT'(addr_valid_q);

        if (frame_tick) begin
            // Launch (or restart) the dimension fetch from any state.
            state_d       = FETCH;
            cnt_d         = '0;
            mem_addr_d    = A_DIM;
            frame_start_d = 1'b1;
            mode_d        = (mode == 2'd3) ? 2'd0 : mode;
        end else begin
            case (state_q)
                FETCH: begin
                    // The fetch address went out when cnt was 0, so data is
                    // on mem_rdata once MEM_LAT cycles have passed.
                    if (cnt_q == CNT_LAST) begin
                        dim_d       = dim_ok ? mem_rdata : D_DEF;
                        ptr_d       = (mode_q == 2'd1) ? A_INTERP : A_ORIG;
                        row_start_d = (mode_q == 2'd1) ? A_INTERP : A_ORIG;
                        state_d     = ACTIVE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ACTIVE: begin
                    if (pix_tick && in_win) begin
                        mem_addr_d   = ptr_q;
                        addr_valid_d = 1'b1;
                        if (mode_q != 2'd2) begin
                            ptr_d = ptr_q + A_ONE;
                        end else if (last_col) begin
                            // Zoom: each source row is shown twice; rewind after
                            // the first copy, move on after the second.
                            if (row_odd) begin
                                ptr_d       = ptr_q + A_ONE;
                                row_start_d = ptr_q + A_ONE;
                            end else begin
                                ptr_d = row_start_q;
                            end
                        end else if (col_odd) begin
                            ptr_d = ptr_q + A_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mode_q        <= 2'd0;
            cnt_q         <= '0;
            ptr_q         <= '0;
            row_start_q   <= '0;
            mem_addr_q    <= '0;
            addr_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            dim_q         <= D_DEF;
            pen_sr_q      <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            cnt_q         <= cnt_d;
            ptr_q         <= ptr_d;
            row_start_q   <= row_start_d;
            mem_addr_q    <= mem_addr_d;
            addr_valid_q  <= addr_valid_d;
            frame_start_q <= frame_start_d;
            dim_q         <= dim_d;
            pen_sr_q      <= pen_sr_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign addr_valid  = addr_valid_q;
    assign frame_start = frame_start_q;
    assign pixel_en    = pen_sr_q[MEM_LAT-1];

endmodule

// File: tb/tb_vga_window_address.sv
// tb/tb_vga_window_address.sv - randomized self-checking bench for vga_window_address
module tb_vga_window_address;

    localparam int H0 = 145;
    localparam int V0 = 35;

    logic        clk = 1'b0;
    logic        rst, pix_tick;
    logic [9:0]  x, y;
    logic [1:0]  mode;
    logic [15:0] mem_dim;

    logic [18:0] addr1, addr3;
    logic        av1, av3, pe1, pe3, fs1, fs3;
    logic [15:0] dim1, dim3, rd1;
    logic [15:0] p3 [0:2];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    always #5 clk = ~clk;

    vga_window_address #(.MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .x(x), .y(y), .mode(mode),
        .mem_rdata(rd1), .mem_addr(addr1), .addr_valid(av1), .pixel_en(pe1),
        .dim_q(dim1), .frame_start(fs1));

    vga_window_address #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .pix_tick(pix_tick), .x(x), .y(y), .mode(mode),
        .mem_rdata(p3[2]), .mem_addr(addr3), .addr_valid(av3), .pixel_en(pe3),
        .dim_q(dim3), .frame_start(fs3));

    function automatic logic [15:0] mem_word(input logic [18:0] a);
        return (a == 19'd2) ? mem_dim : (a[15:0] ^ 16'hA5A5);
    endfunction

    // Synchronous memories with read latency 1 and 3.
    always @(posedge clk) rd1 <= mem_word(addr1);
    always @(posedge clk) begin
        p3[0] <= mem_word(addr3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_dim(input int d);
        return (d == 0 || d > 480) ? 392 : d;
    endfunction

    function automatic int win_size(input int md, input int d);
        case (md)
            1:       return (d < 4) ? 0 : (d / 4) * 3 - 2;
            2:       return 2 * d;
            default: return d;
        endcase
    endfunction

    // Framebuffer address of window pixel (dx,dy) straight from the image layout.
    function automatic logic [18:0] pix_addr(input int md, input int d, input int dx, input int dy);
        int w;
        int a;
        w = win_size(md, d);
        case (md)
            1:       a = 'h3D289 + dy * w + dx;
            2:       a = 5 + (dy / 2) * d + dx / 2;
            default: a = 5 + dy * w + dx;
        endcase
        return a[18:0];
    endfunction

    // Reference model: predicts, each cycle, what both DUTs show next cycle.
    initial begin
        int          m_mode, m_dim, w, dx, dy;
        bit          m_active;
        logic        e_av, e_fs, nav, nfs;
        logic [18:0] e_addr;
        logic [3:0]  hist;
        m_mode = 0; m_dim = 392; m_active = 0;
        e_av = 0; e_fs = 0; e_addr = '0; hist = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("addr_valid1", av1, e_av);
                check("addr_valid3", av3, e_av);
                check("mem_addr1", addr1, e_addr);
                check("mem_addr3", addr3, e_addr);
                check("frame_start1", fs1, e_fs);
                check("frame_start3", fs3, e_fs);
                check("pixel_en1", pe1, hist[1]);
                check("pixel_en3", pe3, hist[3]);
            end
            nav = 0;
            nfs = 0;
            if (rst) begin
                m_active = 0; m_dim = 392; m_mode = 0; e_addr = '0; hist = '0;
            end else if (pix_tick && x == 0 && y == 0) begin
                nfs      = 1;
                m_mode   = (mode == 2'd3) ? 0 : int'(mode);
                m_dim    = eff_dim(int'(mem_dim));
                m_active = 1;
                e_addr   = 19'd2;
            end else if (pix_tick && m_active) begin
                w  = win_size(m_mode, m_dim);
                dx = int'(x) - H0;
                dy = int'(y) - V0;
                if (dx >= 0 && dx < w && dy >= 0 && dy < w) begin
                    nav    = 1;
                    e_addr = pix_addr(m_mode, m_dim, dx, dy);
                end
            end
            hist = {hist[2:0], nav};
            e_av = nav;
            e_fs = nfs;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input int tx, input int ty, input int gap);
        x = tx[9:0];
        y = ty[9:0];
        pix_tick = 1'b1;
        step();
        pix_tick = 1'b0;
        repeat (gap) step();
    endtask

    task automatic frame(input int md, input int d);
        mode    = md[1:0];
        mem_dim = d[15:0];
        tick(0, 0, 8);
        check("dim_q1", dim1, eff_dim(d));
        check("dim_q3", dim3, eff_dim(d));
    endtask

    task automatic scan(input int w, input bit rnd, input int sw_row);
        for (int yy = V0 - 1; yy <= V0 + w; yy++) begin
            for (int xx = H0 - 1; xx <= H0 + w; xx++) begin
                if (yy == sw_row && xx == H0 - 1) mode = 2'd1;
                if (rnd && $urandom_range(0, 7) == 0)
                    tick($urandom_range(600, 799), $urandom_range(1, 500), 0);
                if (rnd && $urandom_range(0, 15) == 0)
                    mode = 2'($urandom_range(0, 3));
                tick(xx, yy, rnd ? $urandom_range(0, 2) : 0);
            end
        end
    endtask

    initial begin
        int md, d;
        rst = 1'b1; pix_tick = 1'b0; x = '0; y = '0; mode = 2'd0; mem_dim = '0;
        step();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_dim_q1", dim1, 392);
        check("reset_dim_q3", dim3, 392);

        // Directed modes.
        frame(0, 4);  scan(4, 0, -1);
        frame(1, 8);  scan(4, 0, -1);
        frame(2, 2);  scan(4, 0, -1);

        // Invalid and degenerate dimensions.
        frame(0, 0);
        tick(145, 35, 0); tick(146, 35, 0); tick(537, 35, 0); tick(144, 36, 0); tick(150, 427, 1);
        frame(0, 600);
        tick(145, 35, 0); tick(536 + 1, 40, 0); tick(144, 100, 0); tick(160, 427, 1);
        frame(1, 3);
        tick(145, 35, 0); tick(146, 35, 0); tick(145, 36, 2);

        // Mode request changes mid-frame, taken at the next frame start.
        frame(0, 6);  scan(6, 0, V0 + 3);
        frame(int'(mode), 8); scan(4, 0, -1);

        // Reset in the middle of the window blanks the rest of the frame.
        frame(0, 4);
        tick(145, 35, 0); tick(146, 35, 0);
        rst = 1'b1; x = 10'd147; y = 10'd35; pix_tick = 1'b1;
        step(); step(); step();
        rst = 1'b0; pix_tick = 1'b0;
        check("midreset_dim_q1", dim1, 392);
        check("midreset_dim_q3", dim3, 392);
        tick(148, 35, 0); tick(145, 36, 0); tick(146, 36, 1);
        frame(2, 3);  scan(6, 0, -1);

        // Frame-start tick repeated during the fetch restarts it.
        mode = 2'd0; mem_dim = 16'd5;
        tick(0, 0, 0);
        mem_dim = 16'd3;
        tick(0, 0, 8);
        check("restart_dim_q1", dim1, 3);
        check("restart_dim_q3", dim3, 3);
        scan(3, 0, -1);

        // Randomized frames.
        repeat (8) begin
            md = $urandom_range(0, 3);
            d  = $urandom_range(1, 10);
            frame(md, d);
            scan(win_size((md == 3) ? 0 : md, d), 1, -1);
        end

        idle_out();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic idle_out();
        pix_tick = 1'b0;
        repeat (6) step();
    endtask

endmodule
